// File: rtl/id_exe_reg_pkg.sv
// Shared core package: execute-command encodings, decoded control word and
// datapath width defaults used by the ID/EXE pipeline register.
package id_exe_reg_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 4;

    typedef enum logic [3:0] {
        EXE_NOP = 4'b0000,
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_e;

    typedef struct packed {
        logic     mem_r_en;
        logic     mem_w_en;
        logic     wb_en;
        logic     b;
        logic     s;
        exe_cmd_e exe_cmd;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '{
        mem_r_en: 1'b0,
        mem_w_en: 1'b0,
        wb_en:    1'b0,
        b:        1'b0,
        s:        1'b0,
        exe_cmd:  EXE_NOP
    };

    // An invalid slot must never produce side effects downstream.
    function automatic ctrl_word_t mask_ctrl(input ctrl_word_t c, input logic v);
        return v ? c : CTRL_NOP;
    endfunction

endpackage

// File: rtl/id_exe_reg_field.sv
// pipe_field_reg: one field group of a pipeline register with
// synchronous reset, hold and clear (priority rst > hold > clr > load).
module pipe_field_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (!hold) begin
            if (clr) begin
                q <= '0;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with freeze, flush, bubble and valid tagging.
// Optional macro ID_EXE_FORWARDING_EN builds the src1/src2 registers.
module id_exe_reg
    import id_exe_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              bubble,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              wb_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm24_in,
    input  logic [REG_AW-1:0] dest_in,
    input  logic [REG_AW-1:0] src1_in,
    input  logic [REG_AW-1:0] src2_in,
    input  logic              c_in,
    output logic [DATA_W-1:0] pc_out,
    output logic [3:0]        exe_cmd_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              wb_en_out,
    output logic              b_out,
    output logic              s_out,
    output logic [DATA_W-1:0] val_rn_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic              imm_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       signed_imm24_out,
    output logic [REG_AW-1:0] dest_out,
    output logic [REG_AW-1:0] src1_out,
    output logic [REG_AW-1:0] src2_out,
    output logic              c_out,
    output logic              valid_out
);

    localparam int CTRL_W = $bits(ctrl_word_t);
    localparam int OPND_W = 1 + 12 + 24 + 1;

    ctrl_word_t         ctrl_d;
    ctrl_word_t         ctrl_q;
    ctrl_word_t         ctrl_masked;
    logic [CTRL_W-1:0]  ctrl_bits_q;
    logic [OPND_W-1:0]  opnd_q;
    logic               valid_q;
    logic               kill_ctrl;

    always_comb begin
        ctrl_d          = CTRL_NOP;
        ctrl_d.mem_r_en = mem_r_en_in;
        ctrl_d.mem_w_en = mem_w_en_in;
        ctrl_d.wb_en    = wb_en_in;
        ctrl_d.b        = b_in;
        ctrl_d.s        = s_in;
        ctrl_d.exe_cmd  = exe_cmd_e'(exe_cmd_in);
    end

    // Bubble kills only the control word; datapath fields still load.
    assign kill_ctrl = flush | bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (!freeze) begin
            valid_q <= !kill_ctrl;
        end
    end

    pipe_field_reg #(.W(CTRL_W)) u_ctrl (
        .clk  (clk),
        .rst  (rst),
        .hold (freeze),
        .clr  (kill_ctrl),
        .d    (ctrl_d),
        .q    (ctrl_bits_q)
    );

    pipe_field_reg #(.W(DATA_W)) u_pc (
        .clk  (clk),
        .rst  (rst),
        .hold (freeze),
        .clr  (flush),
        .d    (pc_in),
        .q    (pc_out)
    );

    pipe_field_reg #(.W(2 * DATA_W)) u_vals (
        .clk  (clk),
        .rst  (rst),
        .hold (freeze),
        .clr  (flush),
        .d    ({val_rn_in, val_rm_in}),
        .q    ({val_rn_out, val_rm_out})
    );

    pipe_field_reg #(.W(OPND_W)) u_opnd (
        .clk  (clk),
        .rst  (rst),
        .hold (freeze),
        .clr  (flush),
        .d    ({imm_in, shift_operand_in, signed_imm24_in, c_in}),
        .q    (opnd_q)
    );

    pipe_field_reg #(.W(REG_AW)) u_dest (
        .clk  (clk),
        .rst  (rst),
        .hold (freeze),
        .clr  (flush),
        .d    (dest_in),
        .q    (dest_out)
    );

`ifdef ID_EXE_FORWARDING_EN
    pipe_field_reg #(.W(2 * REG_AW)) u_src (
        .clk  (clk),
        .rst  (rst),
        .hold (freeze),
        .clr  (flush),
        .d    ({src1_in, src2_in}),
        .q    ({src1_out, src2_out})
    );
`else
    logic unused_src;
    assign unused_src = ^{src1_in, src2_in};
    assign src1_out   = '0;
    assign src2_out   = '0;
`endif

    assign ctrl_q      = ctrl_word_t'(ctrl_bits_q);
    assign ctrl_masked = mask_ctrl(ctrl_q, valid_q);

    assign exe_cmd_out  = ctrl_masked.exe_cmd;
    assign mem_r_en_out = ctrl_masked.mem_r_en;
    assign mem_w_en_out = ctrl_masked.mem_w_en;
    assign wb_en_out    = ctrl_masked.wb_en;
    assign b_out        = ctrl_masked.b;
    assign s_out        = ctrl_masked.s;
    assign valid_out    = valid_q;

    assign imm_out           = opnd_q[OPND_W-1];
    assign shift_operand_out = opnd_q[OPND_W-2 -: 12];
    assign signed_imm24_out  = opnd_q[24:1];
    assign c_out             = opnd_q[0];

endmodule

// File: tb/tb_id_exe_reg.sv
// Self-checking bench for id_exe_reg: directed scenarios followed by random
// control/data stimulus against a slot-level reference model.
module tb_id_exe_reg;
    import id_exe_reg_pkg::*;

`ifdef ID_EXE_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, freeze, flush, bubble;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic [3:0]  exe_cmd_in, dest_in, src1_in, src2_in;
    logic        mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, imm_in, c_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm24_in;

    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out;
    logic        mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out;
    logic        imm_out, c_out, valid_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm24_out;

    typedef struct {
        logic [31:0] pc, rn, rm;
        logic [3:0]  cmd, dest, s1, s2;
        logic        mr, mw, wb, b, s, imm, c, v;
        logic [11:0] sh;
        logic [23:0] off;
    } slot_t;

    slot_t exp_slot;
    int    total = 0;
    int    bad   = 0;

    id_exe_reg #(.DATA_W(32), .REG_AW(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .bubble(bubble),
        .pc_in(pc_in), .exe_cmd_in(exe_cmd_in), .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in), .b_in(b_in), .s_in(s_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
        .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .c_in(c_in),
        .pc_out(pc_out), .exe_cmd_out(exe_cmd_out), .mem_r_en_out(mem_r_en_out),
        .mem_w_en_out(mem_w_en_out), .wb_en_out(wb_en_out), .b_out(b_out),
        .s_out(s_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
        .imm_out(imm_out), .shift_operand_out(shift_operand_out),
        .signed_imm24_out(signed_imm24_out), .dest_out(dest_out),
        .src1_out(src1_out), .src2_out(src2_out), .c_out(c_out),
        .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic slot_t empty_slot();
        slot_t e;
        e = '{default: '0};
        return e;
    endfunction

    function automatic slot_t incoming_slot();
        slot_t n;
        n.pc = pc_in;  n.rn = val_rn_in;  n.rm = val_rm_in;
        n.cmd = exe_cmd_in;  n.dest = dest_in;  n.s1 = src1_in;  n.s2 = src2_in;
        n.mr = mem_r_en_in;  n.mw = mem_w_en_in;  n.wb = wb_en_in;
        n.b = b_in;  n.s = s_in;  n.imm = imm_in;  n.c = c_in;
        n.sh = shift_operand_in;  n.off = signed_imm24_in;
        n.v = 1'b1;
        return n;
    endfunction

    // Slot-level behaviour at one clock edge.
    function automatic slot_t next_slot(input slot_t cur);
        slot_t n;
        if (rst)         return empty_slot();
        if (freeze)      return cur;
        if (flush)       return empty_slot();
        n = incoming_slot();
        if (bubble) begin
            n.cmd = 4'b0000;
            n.mr = 1'b0;  n.mw = 1'b0;  n.wb = 1'b0;  n.b = 1'b0;  n.s = 1'b0;
            n.v = 1'b0;
        end
        return n;
    endfunction

    task automatic check_all();
        check("pc",      pc_out,            exp_slot.pc);
        check("exe_cmd", {28'd0, exe_cmd_out}, {28'd0, exp_slot.cmd});
        check("ctrl",    {27'd0, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out},
                         {27'd0, exp_slot.mr, exp_slot.mw, exp_slot.wb, exp_slot.b, exp_slot.s});
        check("val_rn",  val_rn_out,        exp_slot.rn);
        check("val_rm",  val_rm_out,        exp_slot.rm);
        check("operand", {imm_out, c_out, shift_operand_out, 6'd0},
                         {exp_slot.imm, exp_slot.c, exp_slot.sh, 6'd0});
        check("imm24",   {8'd0, signed_imm24_out}, {8'd0, exp_slot.off});
        check("dest",    {28'd0, dest_out},  {28'd0, exp_slot.dest});
        check("src",     {24'd0, src1_out, src2_out},
                         FWD ? {24'd0, exp_slot.s1, exp_slot.s2} : 32'd0);
        check("valid",   {31'd0, valid_out}, {31'd0, exp_slot.v});
    endtask

    task automatic step();
        @(posedge clk);
        exp_slot = next_slot(exp_slot);
        #1;
        check_all();
    endtask

    task automatic clear_in();
        rst = 1'b0;  freeze = 1'b0;  flush = 1'b0;  bubble = 1'b0;
        pc_in = '0;  val_rn_in = '0;  val_rm_in = '0;
        exe_cmd_in = '0;  dest_in = '0;  src1_in = '0;  src2_in = '0;
        mem_r_en_in = 1'b0;  mem_w_en_in = 1'b0;  wb_en_in = 1'b0;
        b_in = 1'b0;  s_in = 1'b0;  imm_in = 1'b0;  c_in = 1'b0;
        shift_operand_in = '0;  signed_imm24_in = '0;
    endtask

    task automatic random_data();
        pc_in = $urandom;  val_rn_in = $urandom;  val_rm_in = $urandom;
        exe_cmd_in = 4'($urandom_range(0, 15));
        dest_in = 4'($urandom);  src1_in = 4'($urandom);  src2_in = 4'($urandom);
        {mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, imm_in, c_in} = 7'($urandom);
        shift_operand_in = 12'($urandom);  signed_imm24_in = 24'($urandom);
    endtask

    initial begin
        exp_slot = empty_slot();

        // Reset with every input nonzero
        clear_in();
        pc_in = '1;  val_rn_in = '1;  val_rm_in = '1;  exe_cmd_in = '1;
        dest_in = '1;  src1_in = '1;  src2_in = '1;
        {mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, imm_in, c_in} = '1;
        shift_operand_in = '1;  signed_imm24_in = '1;
        freeze = 1'b1;  flush = 1'b1;  bubble = 1'b1;  rst = 1'b1;
        step();
        step();
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_pc", pc_out, 32'd0);

        // Plain load
        clear_in();
        exe_cmd_in = EXE_ADD;  wb_en_in = 1'b1;  dest_in = 4'd3;
        val_rn_in = 32'h0000_0005;  pc_in = 32'h10;
        step();
        check("load_cmd", {28'd0, exe_cmd_out}, 32'd2);
        check("load_valid", {31'd0, valid_out}, 32'd1);
        check("load_pc", pc_out, 32'h10);

        // LDR followed by a bubble with an ADD on the inputs
        clear_in();
        exe_cmd_in = EXE_ADD;  mem_r_en_in = 1'b1;  wb_en_in = 1'b1;  dest_in = 4'd1;
        step();
        exe_cmd_in = EXE_ADD;  mem_r_en_in = 1'b0;  val_rn_in = 32'h0000_1234;
        bubble = 1'b1;
        step();
        check("bub_mem_r", {31'd0, mem_r_en_out}, 32'd0);
        check("bub_wb", {31'd0, wb_en_out}, 32'd0);
        check("bub_valid", {31'd0, valid_out}, 32'd0);
        check("bub_rn", val_rn_out, 32'h0000_1234);

        // Branch then flush, then normal flow again
        clear_in();
        b_in = 1'b1;  pc_in = 32'h40;  signed_imm24_in = 24'h00_0010;
        step();
        flush = 1'b1;
        step();
        check("flush_pc", pc_out, 32'd0);
        check("flush_b", {31'd0, b_out}, 32'd0);
        clear_in();
        exe_cmd_in = EXE_SUB;  pc_in = 32'h48;
        step();
        check("after_flush_valid", {31'd0, valid_out}, 32'd1);

        // STR held under freeze+flush, then flush takes effect
        clear_in();
        exe_cmd_in = EXE_ADD;  mem_w_en_in = 1'b1;  val_rm_in = 32'hCAFE_0001;
        step();
        freeze = 1'b1;  flush = 1'b1;  val_rm_in = 32'h0;  mem_w_en_in = 1'b0;
        for (int unsigned i = 0; i < 3; i++) step();
        check("frz_mem_w", {31'd0, mem_w_en_out}, 32'd1);
        check("frz_rm", val_rm_out, 32'hCAFE_0001);
        freeze = 1'b0;
        step();
        check("unfrz_mem_w", {31'd0, mem_w_en_out}, 32'd0);
        check("unfrz_valid", {31'd0, valid_out}, 32'd0);

        // Source register numbers for forwarding
        clear_in();
        src1_in = 4'd7;  src2_in = 4'd9;
        step();
        check("fwd_src1", {28'd0, src1_out}, FWD ? 32'd7 : 32'd0);
        check("fwd_src2", {28'd0, src2_out}, FWD ? 32'd9 : 32'd0);

        // Random mix of controls and data
        for (int unsigned i = 0; i < 600; i++) begin
            random_data();
            rst    = ($urandom_range(0, 24) == 0);
            freeze = ($urandom_range(0, 4) == 0);
            flush  = ($urandom_range(0, 5) == 0);
            bubble = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_exe_reg.md
# id_exe_reg

ID/EXE pipeline register of the five-stage ARM-subset core. It captures the decoded control word (execute command, memory enables, write-back enable, branch, status-update) and datapath operands produced in the decode stage. It presents them to the execute stage one cycle later. It supports whole-pipeline freeze, branch flush, and hazard bubble insertion, and tags every slot with a valid bit.

## Interface
Parameters:
- DATA_W, 32, width of PC and register operands
- REG_AW, 4, register-number width

Ports (name, direction, width, meaning):
- clk  in  1  single core clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- freeze  in  1  hold all contents (memory-stage stall)
- flush  in  1  taken branch in EXE; kill slot
- bubble  in  1  hazard detected; insert NOP in place of incoming instruction
- pc_in  in  DATA_W  PC+4 of decoded instruction
- exe_cmd_in  in  4  ALU command
- mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in  in  1 each  decoded control bits
- val_rn_in, val_rm_in  in  DATA_W  register-file read values
- imm_in  in  1  I bit
- shift_operand_in  in  12  shifter operand field
- signed_imm24_in  in  24  branch offset
- dest_in  in  REG_AW  destination register
- src1_in, src2_in  in  REG_AW  source register numbers
- c_in  in  1  current status-register carry flag
- All of the above mirrored as `*_out` outputs (same widths), plus `valid_out`  out  1.

## Operation
- Update priority each rising edge: rst > freeze > flush > bubble > load.
- rst: every output goes to 0, including valid_out, exe_cmd_out=4'b0000, and pc_out=0.
- freeze: all registers hold, even when flush or bubble is also high. A branch held in EXE keeps asserting flush, so the flush still takes effect once freeze drops.
- flush, without freeze: every output is cleared to 0, as on reset, and valid_out becomes 0.
- bubble, without freeze or flush:
  - Control bits (mem_r_en, mem_w_en, wb_en, b, s) and valid_out are cleared to 0, and exe_cmd_out becomes 0.
  - Datapath fields still load from the inputs.
  - Result: a NOP that writes nothing, touches no memory, and never updates status.
- load (no other condition): all `*_out` take their `*_in` values and valid_out becomes 1.
- Control outputs are masked with valid, so an invalid slot can never write memory, write back, branch, or set status.
- No arithmetic is done; fields pass through bit-exact at their declared widths.

## Timing
- Latency: 1 cycle from input to output.
- No combinational path from any input to any output.
- flush and bubble asserted in cycle N make the outputs in cycle N+1 a NOP.
- freeze asserted in cycle N keeps the cycle-N+1 outputs equal to the cycle-N outputs.
- Reset applied mid-stream clears the slot on the next edge, regardless of freeze.
- flush/freeze/bubble are sampled only at the clock edge; glitches between edges are ignored.

## Configuration
- `ID_EXE_FORWARDING_EN` defined: src1_out/src2_out are registered like the other fields and feed the forwarding unit.
- `ID_EXE_FORWARDING_EN` undefined: the src1/src2 registers are not built and src1_out/src2_out are tied to 0. Behaviour is otherwise identical.

## Structure
- The shared core package holds:
  - EXE_CMD encodings (MOV 0001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, MVN 1001, NOP 0000)
  - the control-word packed struct {mem_r_en, mem_w_en, wb_en, b, s, exe_cmd}
  - the DATA_W/REG_AW defaults
- One small sub-module, `pipe_field_reg` (parameterised width, load/clear/hold), is instantiated per field group. The valid/priority logic lives at the top level.

## Test plan
- Reset: drive all inputs nonzero, rst=1 for 2 cycles -> every output 0 and valid_out=0.
- Load: exe_cmd_in=0010, wb_en_in=1, dest_in=4'd3, val_rn_in=32'h0000_0005, pc_in=32'h10 -> next cycle the same values appear on the outputs and valid_out=1.
- Bubble: load LDR (mem_r_en=1, wb_en=1), then bubble=1 with an ADD on the inputs -> outputs have mem_r_en=0, wb_en=0, exe_cmd=0000, valid_out=0, and val_rn_out equal to the ADD's val_rn.
- Flush: b_in=1 loaded, then flush=1 -> next cycle all outputs 0. A following load without flush restores normal flow.
- Freeze with flush: outputs hold an STR (mem_w_en=1); assert freeze=1 and flush=1 for 3 cycles -> outputs unchanged. Drop freeze with flush still 1 -> outputs cleared.
- Forwarding: src1_in=4'd7, src2_in=4'd9 -> with the macro, outputs 7/9 after one cycle; without it, outputs 0/0.
